sprite_actor: RTL and testbench

SPRITE_ACTOR -- requirements
Module: sprite_actor

---
 rtl/sprite_actor.sv | 212 +++++++++++++++++++++
 tb/tb_sprite_actor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_actor.sv
// Side-scroller runner sprite: jump/fall physics stepped per video frame,
// plus a 3-stage ROM lookup pipeline that renders the sprite box.
module sprite_actor #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int SCALE_SHIFT = 2,
    parameter int RUN_FRAMES = 6,
    parameter int ANIM_DIV = 10000000,
    parameter int X_POS = 220,
    parameter int GROUND_Y = 500,
    parameter int JUMP_V0 = 24,
    parameter int GRAVITY = 1,
    parameter int MAX_AIR_JUMPS = 1,
    parameter int LAND_TICKS = 3,
    parameter logic [11:0] TRANSPARENT = 12'hC0F,
    localparam int ADDR_W = $clog2((RUN_FRAMES + 3) * SPR_W * SPR_H)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic              jump_key,
    input  logic              visible,
    input  logic [11:0]       display_col,
    input  logic [10:0]       display_row,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [3:0]        char_red,
    output logic [3:0]        char_green,
    output logic [3:0]        char_blue,
    output logic              char_visible,
    output logic [10:0]       char_top,
    output logic              airborne
);

    localparam int SPR_PIX = SPR_W << SCALE_SHIFT;
    localparam int SPR_PIY = SPR_H << SCALE_SHIFT;
    localparam int H_MAX = GROUND_Y - SPR_PIY;
    localparam int FR_W = $clog2(RUN_FRAMES + 3);
    localparam int AN_W = $clog2(ANIM_DIV + 1);
    localparam int AJ_W = $clog2(MAX_AIR_JUMPS + 2);
    localparam int LC_W = $clog2(LAND_TICKS + 1);

    localparam logic signed [11:0] H_MAX_S = 12'(H_MAX);
    localparam logic [10:0] TOP_GND = 11'(H_MAX);
    localparam logic signed [10:0] V0 = 11'(JUMP_V0);
    localparam logic signed [10:0] GRAV = 11'(GRAVITY);
    localparam logic [AN_W-1:0] AN_LAST = AN_W'(ANIM_DIV - 1);
    localparam logic [FR_W-1:0] RF_LAST = FR_W'(RUN_FRAMES - 1);
    localparam logic [AJ_W-1:0] AJ_MAX = AJ_W'(MAX_AIR_JUMPS);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LAND_TICKS - 1);

    // Bit 1 of the encoding is the airborne flag itself.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        LAND = 2'b01,
        RISE = 2'b10,
        FALL = 2'b11
    } state_t;

    state_t                 state;
    logic [9:0]             h;
    logic signed [10:0]     v;
    logic [AJ_W-1:0]        air_jumps;
    logic                   pending;
    logic [LC_W-1:0]        land_cnt;
    logic [FR_W-1:0]        run_frame;
    logic [FR_W-1:0]        frame;
    logic [AN_W-1:0]        anim_cnt;
    logic                   jump_q;
    logic                   jump_edge;
    logic                   air_ok;
    logic signed [11:0]     h_sum;
    logic signed [10:0]     v_dec;

    assign jump_edge = jump_key & ~jump_q;
    assign air_ok = air_jumps < AJ_MAX;
    assign h_sum = $signed({2'b00, h}) + $signed({v[10], v});
    assign v_dec = v - GRAV;
    assign airborne = state[1];

    always_comb begin
        unique case (state)
            RISE:    frame = FR_W'(RUN_FRAMES);
            FALL:    frame = FR_W'(RUN_FRAMES + 1);
            LAND:    frame = FR_W'(RUN_FRAMES + 2);
            default: frame = run_frame;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            h         <= '0;
            v         <= '0;
            air_jumps <= '0;
            pending   <= 1'b0;
            land_cnt  <= '0;
            run_frame <= '0;
            anim_cnt  <= '0;
            jump_q    <= 1'b0;
            char_top  <= TOP_GND;
        end else begin
            jump_q   <= jump_key;
            char_top <= TOP_GND - {1'b0, h};
            if (enable) begin
                unique case (state)
                    RUN: begin
                        if (anim_cnt == AN_LAST) begin
                            anim_cnt  <= '0;
                            run_frame <= (run_frame == RF_LAST) ? '0 : run_frame + 1'b1;
                        end else begin
                            anim_cnt <= anim_cnt + 1'b1;
                        end
                        if (jump_edge) begin
                            state     <= RISE;
                            v         <= V0;
                            air_jumps <= '0;
                        end
                    end
                    RISE, FALL: begin
                        if (jump_edge && air_ok) begin
                            state     <= RISE;
                            v         <= V0;
                            air_jumps <= air_jumps + 1'b1;
                        end else if (frame_tick) begin
                            if (h_sum <= 12'sd0) begin
                                state    <= LAND;
                                h        <= '0;
                                v        <= '0;
                                land_cnt <= '0;
                                pending  <= 1'b0;
                            end else if (h_sum > H_MAX_S) begin
                                state <= FALL;
                                h     <= H_MAX_S[9:0];
                                v     <= '0;
                            end else begin
                                state <= (v_dec > 11'sd0) ? RISE : FALL;
                                h     <= h_sum[9:0];
                                v     <= v_dec;
                            end
                        end
                    end
                    LAND: begin
                        if (jump_edge) pending <= 1'b1;
                        if (frame_tick) begin
                            if (land_cnt == LC_LAST) begin
                                // A jump queued during landing fires as LAND ends.
                                if (pending || jump_edge) begin
                                    state     <= RISE;
                                    v         <= V0;
                                    air_jumps <= '0;
                                end else begin
                                    state <= RUN;
                                end
                                pending <= 1'b0;
                            end else begin
                                land_cnt <= land_cnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    logic [11:0]       dx;
    logic [10:0]       dy;
    logic              in_x;
    logic              in_y;
    logic              hit;
    logic              hit1;
    logic              hit2;
    logic [ADDR_W-1:0] addr_n;

    assign dx = display_col - 12'(X_POS);
    assign dy = display_row - char_top;
    assign in_x = (display_col >= 12'(X_POS)) && (display_col < 12'(X_POS + SPR_PIX));
    assign in_y = (display_row >= char_top) && (display_row < char_top + 11'(SPR_PIY));
    assign hit = visible && in_x && in_y;
    assign addr_n = ADDR_W'(32'(frame) * (SPR_W * SPR_H)
                  + 32'(dy >> SCALE_SHIFT) * SPR_W
                  + 32'(dx >> SCALE_SHIFT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_addr     <= '0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            char_red     <= '0;
            char_green   <= '0;
            char_blue    <= '0;
            char_visible <= 1'b0;
        end else begin
            rom_addr <= addr_n;
            hit1     <= hit;
            hit2     <= hit1;
            if (hit2 && rom_data != TRANSPARENT) begin
                char_red     <= rom_data[3:0];
                char_green   <= rom_data[7:4];
                char_blue    <= rom_data[11:8];
                char_visible <= 1'b1;
            end else begin
                char_red     <= 4'hF;
                char_green   <= 4'hF;
                char_blue    <= 4'hF;
                char_visible <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_actor.sv
// Directed bench for sprite_actor: physics, jumps, animation and render pipe.
module tb_sprite_actor;

    localparam int ADDR_W = 14;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              frame_tick = 1'b0;
    logic              jump_key = 1'b0;
    logic              visible = 1'b0;
    logic [11:0]       display_col = '0;
    logic [10:0]       display_row = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [11:0]       rom_word = '0;
    logic [3:0]        char_red;
    logic [3:0]        char_green;
    logic [3:0]        char_blue;
    logic              char_visible;
    logic [10:0]       char_top;
    logic              airborne;

    int n_checks = 0;
    int n_fails = 0;

    sprite_actor #(.ANIM_DIV(4)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .frame_tick(frame_tick),
        .jump_key(jump_key),
        .visible(visible),
        .display_col(display_col),
        .display_row(display_row),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .char_red(char_red),
        .char_green(char_green),
        .char_blue(char_blue),
        .char_visible(char_visible),
        .char_top(char_top),
        .airborne(airborne)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data one clock after the address.
    always @(posedge clock) rom_data <= rom_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ftick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic press();
        jump_key = 1'b1;
        step();
        jump_key = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_airborne", airborne, 0);
        chk("rst_top", char_top, 372);
        chk("rst_addr", rom_addr, 0);
        chk("rst_vis", char_visible, 0);
        chk("rst_rgb", {char_red, char_green, char_blue}, 0);

        // Render pipeline at h=0
        reset = 1'b0;
        enable = 1'b1;
        display_col = 221;
        display_row = 470;
        rom_word = 12'h0A5;
        repeat (3) step();
        chk("novis_vis", char_visible, 0);
        chk("novis_rgb", {char_red, char_green, char_blue}, 12'hFFF);
        visible = 1'b1;
        step();
        step();
        chk("lat2_vis", char_visible, 0);
        step();
        chk("lat3_vis", char_visible, 1);
        chk("lat3_rgb", {char_red, char_green, char_blue}, 12'h5A0);
        rom_word = 12'hC0F;
        repeat (3) step();
        chk("key_vis", char_visible, 0);
        chk("key_rgb", {char_red, char_green, char_blue}, 12'hFFF);
        rom_word = 12'h0A5;
        display_col = 348;
        repeat (3) step();
        chk("col348_vis", char_visible, 0);
        display_col = 347;
        repeat (3) step();
        chk("col347_vis", char_visible, 1);
        display_row = 500;
        repeat (3) step();
        chk("row500_vis", char_visible, 0);
        display_row = 499;
        repeat (3) step();
        chk("row499_vis", char_visible, 1);

        // Run animation with ANIM_DIV=4
        enable = 1'b0;
        do_reset();
        display_col = 220;
        display_row = 499;
        repeat (3) step();
        chk("anim_f0_frozen", rom_addr, 992);
        enable = 1'b1;
        step();
        chk("anim_f0", rom_addr, 992);
        for (int k = 1; k <= 7; k++) begin
            repeat (4) step();
            chk($sformatf("anim_k%0d", k), rom_addr, (k % 6) * 1024 + 992);
        end
        enable = 1'b0;
        repeat (12) step();
        chk("anim_hold", rom_addr, 2016);

        // Full jump with key held, no retrigger
        enable = 1'b1;
        do_reset();
        jump_key = 1'b1;
        step();
        chk("j_air", airborne, 1);
        ftick(1);
        chk("j_t1_top", char_top, 348);
        display_row = 348;
        step();
        chk("j_rise_frame", rom_addr, 6144);
        ftick(9);
        chk("j_t10_top", char_top, 177);
        ftick(13);
        chk("j_t23_top", char_top, 73);
        ftick(1);
        chk("j_t24_top", char_top, 72);
        display_row = 72;
        step();
        chk("j_fall_frame", rom_addr, 7168);
        ftick(1);
        chk("j_t25_top", char_top, 72);
        ftick(5);
        chk("j_t30_top", char_top, 87);
        jump_key = 1'b0;
        ftick(18);
        chk("j_t48_top", char_top, 348);
        chk("j_t48_air", airborne, 1);
        ftick(1);
        chk("j_t49_air", airborne, 0);
        chk("j_t49_top", char_top, 372);
        display_row = 372;
        step();
        chk("j_land_frame", rom_addr, 8192);
        ftick(2);
        chk("j_t51_land", rom_addr, 8192);
        ftick(1);
        chk("j_t52_run", rom_addr < 6144, 1);
        chk("j_t52_air", airborne, 0);

        // Jump queued during LAND
        press();
        chk("l_air", airborne, 1);
        ftick(49);
        chk("l_t49_air", airborne, 0);
        ftick(1);
        press();
        chk("l_pend_air", airborne, 0);
        ftick(1);
        chk("l_t51_air", airborne, 0);
        ftick(1);
        chk("l_t52_air", airborne, 1);
        chk("l_t52_top", char_top, 372);
        step();
        chk("l_rise_frame", rom_addr, 6144);
        ftick(1);
        chk("l_v0_top", char_top, 348);

        // Air jump, clamp at ceiling, second air jump ignored
        do_reset();
        press();
        ftick(10);
        chk("a_t10_top", char_top, 177);
        jump_key = 1'b1;
        frame_tick = 1'b1;
        step();
        jump_key = 1'b0;
        frame_tick = 1'b0;
        step();
        chk("a_jump_wins", char_top, 177);
        ftick(1);
        chk("a_t11_top", char_top, 153);
        ftick(7);
        chk("a_t18_top", char_top, 13);
        ftick(1);
        chk("a_clamp_top", char_top, 0);
        display_row = 0;
        step();
        chk("a_clamp_fall", rom_addr, 7168);
        ftick(1);
        chk("a_t20_top", char_top, 0);
        press();
        ftick(1);
        chk("a_t21_top", char_top, 1);
        ftick(1);
        chk("a_t22_top", char_top, 3);
        enable = 1'b0;
        ftick(3);
        press();
        chk("a_frozen_top", char_top, 3);
        chk("a_frozen_air", airborne, 1);
        enable = 1'b1;

        // Asynchronous reset mid-jump
        display_col = 221;
        display_row = 10;
        rom_word = 12'h0A5;
        repeat (3) step();
        chk("r_pre_vis", char_visible, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("r_air", airborne, 0);
        chk("r_top", char_top, 372);
        chk("r_addr", rom_addr, 0);
        chk("r_vis", char_visible, 0);
        chk("r_rgb", {char_red, char_green, char_blue}, 0);
        step();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
